// File: rtl/divider_prog.sv
// divider_prog: run-time programmable clock divider with glitch-free ratio changes.
// Optional macro DIVIDER_PROG_PHASE_EN adds phase_val to skew the counter restart point.
module divider_prog #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 6
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             div_en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
`ifdef DIVIDER_PROG_PHASE_EN
  input  logic [CNT_W-1:0] phase_val,
`endif
  output logic             div_err,
  output logic [CNT_W-1:0] div_cur,
  output logic             clk_out,
  output logic             clk_flag
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic             pend_v_q, pend_v_d, out_q, out_d, flag_q, flag_d, err_q, err_d;
  logic             load_ok, wrap;
  logic [CNT_W:0]   half;
`ifdef DIVIDER_PROG_PHASE_EN
  logic             en_q;
`endif
  always_comb begin
    load_ok  = div_load && div_val >= CNT_W'(2);
    wrap     = div_en && cnt_q == div_q - 1'b1;
    err_d    = div_load && !load_ok;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cnt_d    = '0;
    if (!div_en) begin
      div_d    = load_ok ? div_val : div_q;
      pend_v_d = load_ok ? 1'b0 : pend_v_q;
    end else if (wrap) begin
      // a load landing on the wrap edge beats any older pending value
      div_d    = load_ok ? div_val : pend_v_q ? pend_q : div_q;
      pend_v_d = 1'b0;
    end else begin
      cnt_d    = cnt_q + 1'b1;
      pend_d   = load_ok ? div_val : pend_q;
      pend_v_d = load_ok | pend_v_q;
    end
`ifdef DIVIDER_PROG_PHASE_EN
    if (wrap || (div_en && !en_q))
      cnt_d = phase_val < div_d ? phase_val : '0;
`endif
    half   = ({1'b0, div_d} + 1'b1) >> 1;
    out_d  = div_en && {1'b0, cnt_d} >= half;
    flag_d = div_en && cnt_d == div_d - 1'b1;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q    <= '0;
      div_q    <= CNT_W'(DIV_DEFAULT);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      out_q    <= 1'b0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      out_q    <= out_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
    end
  end
`ifdef DIVIDER_PROG_PHASE_EN
  always_ff @(posedge sys_clk) en_q <= sys_rst ? 1'b0 : div_en;
`endif
  assign div_err  = err_q;
  assign div_cur  = div_q;
  assign clk_out  = out_q;
  assign clk_flag = flag_q;
endmodule

// File: tb/tb_divider_prog.sv
// tb_divider_prog: scoreboard bench; expected {clk_flag,clk_out} per cycle is queued from period lengths.
module tb_divider_prog;
  logic       sys_clk = 1'b0, sys_rst = 1'b1, div_en = 1'b1, div_load = 1'b0;
  logic [7:0] div_val = '0;
  logic       div_err, clk_out, clk_flag;
  logic [7:0] div_cur;
  logic [1:0] q[$];
  logic [1:0] e;
  int         n_chk = 0, n_fail = 0;

  divider_prog dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .div_en  (div_en),
    .div_load(div_load),
    .div_val (div_val),
    .div_err (div_err),
    .div_cur (div_cur),
    .clk_out (clk_out),
    .clk_flag(clk_flag)
  );

  always #5 sys_clk = ~sys_clk;

  // queue the first len cycles of a period of length n as {flag,out}
  function automatic void push_part(int n, int len);
    for (int k = 0; k < len; k++) q.push_back({k == n - 1, k >= (n + 1) / 2});
  endfunction

  function automatic void push_period(int n);
    push_part(n, n);
  endfunction

  function automatic void push_zero(int len);
    for (int k = 0; k < len; k++) q.push_back(2'b00);
  endfunction

  task automatic do_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; div_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_chk++;
    if ({clk_flag, clk_out, div_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs got %b expected 000", {clk_flag, clk_out, div_err});
    end
    n_chk++;
    if (div_cur !== 8'd6) begin
      n_fail++; $display("FAIL reset_div_cur got %0d expected 6", div_cur);
    end
    sys_rst = 1'b0;
  endtask

  task automatic test_default();
    do_reset();
    repeat (3) push_period(6);
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front(); n_chk += 3;
      if ({clk_flag, clk_out} !== e) begin n_fail++; $display("FAIL default cycle %0d flag/out got %b expected %b", i, {clk_flag, clk_out}, e); end
      if (div_err !== 1'b0) begin n_fail++; $display("FAIL default_err cycle %0d got %b expected 0", i, div_err); end
      if (div_cur !== 8'd6) begin n_fail++; $display("FAIL default_cur cycle %0d got %0d expected 6", i, div_cur); end
      @(negedge sys_clk);
    end
  endtask

  task automatic test_load_mid();
    do_reset();
    push_period(6); push_period(9); push_period(9);
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front(); n_chk += 2;
      if ({clk_flag, clk_out} !== e) begin n_fail++; $display("FAIL load_mid cycle %0d flag/out got %b expected %b", i, {clk_flag, clk_out}, e); end
      if (div_cur !== (i <= 6 ? 8'd6 : 8'd9)) begin n_fail++; $display("FAIL load_mid_cur cycle %0d got %0d expected %0d", i, div_cur, i <= 6 ? 6 : 9); end
      div_load = (i == 2); div_val = 8'd9;
      @(negedge sys_clk);
    end
    div_load = 1'b0;
  endtask

  task automatic test_load_at_wrap();
    do_reset();
    push_period(6); push_period(4); push_period(3); push_period(3);
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front(); n_chk += 2;
      if ({clk_flag, clk_out} !== e) begin n_fail++; $display("FAIL load_wrap cycle %0d flag/out got %b expected %b", i, {clk_flag, clk_out}, e); end
      if (div_cur !== (i <= 6 ? 8'd6 : i <= 10 ? 8'd4 : 8'd3)) begin n_fail++; $display("FAIL load_wrap_cur cycle %0d got %0d", i, div_cur); end
      div_load = (i == 6 || i == 8); div_val = (i == 6) ? 8'd4 : 8'd3;
      @(negedge sys_clk);
    end
    div_load = 1'b0;
  endtask

  task automatic test_reject();
    do_reset();
    push_period(6); push_period(9);
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front(); n_chk += 3;
      if ({clk_flag, clk_out} !== e) begin n_fail++; $display("FAIL reject cycle %0d flag/out got %b expected %b", i, {clk_flag, clk_out}, e); end
      if (div_err !== (i == 4 || i == 6)) begin n_fail++; $display("FAIL reject_err cycle %0d got %b expected %b", i, div_err, i == 4 || i == 6); end
      if (div_cur !== (i <= 6 ? 8'd6 : 8'd9)) begin n_fail++; $display("FAIL reject_cur cycle %0d got %0d", i, div_cur); end
      div_load = (i == 1 || i == 3 || i == 5);
      div_val = (i == 1) ? 8'd9 : (i == 3) ? 8'd1 : 8'd0;
      @(negedge sys_clk);
    end
    div_load = 1'b0;
  endtask

  task automatic test_enable();
    do_reset();
    push_part(6, 4); push_zero(4); push_period(5); push_period(5);
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front(); n_chk += 2;
      if ({clk_flag, clk_out} !== e) begin n_fail++; $display("FAIL enable cycle %0d flag/out got %b expected %b", i, {clk_flag, clk_out}, e); end
      if (div_cur !== (i <= 6 ? 8'd6 : 8'd5)) begin n_fail++; $display("FAIL enable_cur cycle %0d got %0d", i, div_cur); end
      div_en = !(i >= 4 && i <= 8);
      div_load = (i == 6); div_val = 8'd5;
      @(negedge sys_clk);
    end
    div_load = 1'b0; div_en = 1'b1;
  endtask

  task automatic test_reset_pending();
    do_reset();
    push_part(6, 4); push_period(6); push_period(6);
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front(); n_chk += 2;
      if ({clk_flag, clk_out} !== e) begin n_fail++; $display("FAIL rst_pend cycle %0d flag/out got %b expected %b", i, {clk_flag, clk_out}, e); end
      if (div_cur !== 8'd6) begin n_fail++; $display("FAIL rst_pend_cur cycle %0d got %0d expected 6", i, div_cur); end
      div_load = (i == 2); div_val = 8'd9;
      sys_rst = (i == 4);
      @(negedge sys_clk);
    end
    div_load = 1'b0; sys_rst = 1'b0;
  endtask

  task automatic test_extremes();
    do_reset();
    push_period(6); push_period(255);
    repeat (4) push_period(2);
    for (int i = 1; q.size() > 0; i++) begin
      e = q.pop_front(); n_chk++;
      if ({clk_flag, clk_out} !== e) begin n_fail++; $display("FAIL extremes cycle %0d flag/out got %b expected %b", i, {clk_flag, clk_out}, e); end
      if (i == 7 || i == 262) begin
        n_chk++;
        if (div_cur !== (i == 7 ? 8'd255 : 8'd2)) begin n_fail++; $display("FAIL extremes_cur cycle %0d got %0d", i, div_cur); end
      end
      div_load = (i == 1 || i == 106); div_val = (i == 1) ? 8'd255 : 8'd2;
      @(negedge sys_clk);
    end
    div_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_load_mid();
    test_load_at_wrap();
    test_reject();
    test_enable();
    test_reset_pending();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/divider_prog.md
Name: divider_prog

Overview:
Run-time programmable integer clock divider: a successor to the fixed divide-by-six block, generalised to any ratio N in 2..2^CNT_W-1. Produces a one-cycle enable strobe (clk_flag) and a near-50% divided clock (clk_out) for downstream sys_clk-domain logic such as UART baud ticks, LED scan and sampling strobes. Ratio changes are glitch-free: they are applied only at a period boundary.

Parameters:
CNT_W, 8, width of the period counter and the divisor; the legal ratio is 2..2^CNT_W-1.
DIV_DEFAULT, 6, ratio loaded at reset; must lie in 2..2^CNT_W-1.

Ports:
sys_clk  input  1  system clock; all logic samples on its rising edge.
sys_rst  input  1  synchronous reset, active-high.
div_en  input  1  run enable; 0 holds the counter at 0 and forces both outputs to 0.
div_load  input  1  single-cycle request to change the ratio to div_val.
div_val  input  CNT_W  requested ratio N; sampled only when div_load=1.
div_err  output  1  one-cycle pulse when a load is rejected.
div_cur  output  CNT_W  ratio currently in effect.
clk_out  output  1  divided clock.
clk_flag  output  1  one-cycle strobe, once per period.

Behaviour:
- Reset (sys_rst=1 at a rising edge): cnt=0, div_cur=DIV_DEFAULT, pending register empty; clk_out=0, clk_flag=0, div_err=0. Reset overrides every other input; a mid-period reset discards the period and any pending load.
- Counter: when div_en=1, cnt runs 0,1,...,N-1,0,... with N=div_cur. The wrap occurs on the edge where cnt==N-1.
- All outputs are registered. Each is decoded from the next-state count, so its value during a cycle matches the cnt held in that same cycle (zero added latency).
- clk_flag = 1 exactly in the cycle where cnt==N-1, so it pulses once every N cycles. For N=6, clk_flag is high in the 6th cycle of every period.
- clk_out = 0 while cnt < ceil(N/2), and 1 for the remaining floor(N/2) cycles. Even N gives exactly 50% duty; odd N is low one cycle longer than high.
- First period after reset or after div_en rises: cnt=0 on the first enabled cycle, so the first clk_flag arrives N cycles later.
- div_en=0: on the next edge cnt becomes 0 and clk_out and clk_flag become 0; the counter then holds. div_cur and the pending register are retained.
- Load with div_val in 2..2^CNT_W-1 and div_en=1: div_val is stored in the pending register. It is copied to div_cur on the wrap edge, so the next period uses the new N.
- Load while div_en=0: div_cur is updated on the same edge and any pending value is cleared.
- A second load before the wrap overwrites the pending value (last write wins).
- Load in the same cycle as the wrap (cnt==N-1): the new value takes effect at that wrap, with no extra period at the old ratio.
- Load with div_val < 2: rejected. div_err=1 for exactly one cycle; div_cur and the pending register are unchanged.
- Downstream handshakes are not required; clk_flag is a free-running strobe.

Optional Feature:
Macro DIVIDER_PROG_PHASE_EN.
- Defined: adds input phase_val [CNT_W-1:0]. On the wrap edge and on div_en rising, cnt is loaded with phase_val instead of 0. This shifts clk_flag/clk_out alignment so multiple instances can be skewed.
- If phase_val >= N, it is treated as 0.
- Undefined: the port is absent and the counter always restarts at 0.

Test Plan:
- Reset release with div_en=1 and default N=6 -> clk_flag high in cycles 6, 12, 18; clk_out low for cycles 1-3 and high for cycles 4-6 of each period; div_cur=6.
- Load div_val=9 in cycle 2 of a period -> remainder of that period still 6 cycles; the next clk_flag gap is 9 cycles; clk_out 5 low / 4 high; div_cur changes to 9 at the wrap.
- Load div_val=4 exactly when cnt==5 (N=6), followed by load div_val=3 one cycle into the new period -> the period after the wrap is 4 cycles, the following period is 3 cycles; no runt or double clk_flag.
- Load div_val=1, then div_val=0 -> div_err pulses one cycle each; period stays unchanged; div_cur unchanged.
- Drop div_en mid-period (cnt=3), hold for 5 cycles, then raise it -> outputs are 0 while disabled; after re-enable, clk_flag first occurs N cycles later. Assert sys_rst with a pending load -> div_cur returns to 6 and the pending value is discarded.
- N=2^CNT_W-1 (255) and N=2 -> correct clk_flag spacing of 255 and 2 cycles; clk_out toggles every cycle when N=2; no counter overflow.
